// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants and types for the writeback register file
package proc_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0_IDX = '0;

    // A write only lands in architectural state when enabled and not aimed at x0
    function automatic logic is_commit(input logic reg_write, input reg_addr_t rd);
        return reg_write && (rd != X0_IDX);
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - MEM/WB writeback and decode read bundle
interface writeback_regfile_if #(
    parameter int XLEN = proc_pkg::XLEN
);
    import proc_pkg::*;

    logic                RegWrite_in;
    logic                MemtoReg_in;
    reg_addr_t           rd_in;
    logic [XLEN-1:0]     Result_in;
    logic [XLEN-1:0]     Read_Data_in;
    reg_addr_t           rs1;
    reg_addr_t           rs2;
    logic [XLEN-1:0]     ReadData1;
    logic [XLEN-1:0]     ReadData2;
    logic [XLEN-1:0]     wb_data;
    logic [CNT_W-1:0]    wb_count;

    modport master (
        output RegWrite_in, MemtoReg_in, rd_in, Result_in, Read_Data_in, rs1, rs2,
        input  ReadData1, ReadData2, wb_data, wb_count
    );

    modport slave (
        input  RegWrite_in, MemtoReg_in, rd_in, Result_in, Read_Data_in, rs1, rs2,
        output ReadData1, ReadData2, wb_data, wb_count
    );

endinterface

// File: rtl/writeback_regfile_array.sv
// rtl/writeback_regfile_array.sv - NREGS x XLEN storage, one write port, two async read ports
module regfile_array
    import proc_pkg::*;
#(
    parameter int XLEN  = proc_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  reg_addr_t       waddr,
    input  logic [XLEN-1:0] wdata,
    input  reg_addr_t       raddr1,
    input  reg_addr_t       raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [0:NREGS-1];

    // Clear everything on reset; otherwise take the single write, never into x0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != X0_IDX) && (32'(waddr) < NREGS)) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous reads; x0 and unpopulated indices read as zero
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if ((raddr1 != X0_IDX) && (32'(raddr1) < NREGS)) begin
            rdata1 = mem[raddr1];
        end
        if ((raddr2 != X0_IDX) && (32'(raddr2) < NREGS)) begin
            rdata2 = mem[raddr2];
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback mux, register file and commit counter; WB_BYPASS_EN adds write-to-read bypass
module writeback_regfile
    import proc_pkg::*;
#(
    parameter int XLEN  = proc_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    writeback_regfile_if.slave wb
);

    logic              commit;
    logic [XLEN-1:0]   sel_data;
    logic [XLEN-1:0]   arr_rdata1;
    logic [XLEN-1:0]   arr_rdata2;
    logic [CNT_W-1:0]  wb_cnt_q;

    // Writeback select is purely combinational and ignores enable and reset
    always_comb begin
        sel_data = wb.MemtoReg_in ? wb.Read_Data_in : wb.Result_in;
    end

    assign wb.wb_data  = sel_data;
    assign commit      = is_commit(wb.RegWrite_in, wb.rd_in);
    assign wb.wb_count = wb_cnt_q;

    regfile_array #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (commit),
        .waddr  (wb.rd_in),
        .wdata  (sel_data),
        .raddr1 (wb.rs1),
        .raddr2 (wb.rs2),
        .rdata1 (arr_rdata1),
        .rdata2 (arr_rdata2)
    );

`ifdef WB_BYPASS_EN
    // Forward the in-flight writeback value to a reader of the same register
    always_comb begin
        wb.ReadData1 = arr_rdata1;
        wb.ReadData2 = arr_rdata2;
        if (commit && !reset && (wb.rs1 == wb.rd_in)) begin
            wb.ReadData1 = sel_data;
        end
        if (commit && !reset && (wb.rs2 == wb.rd_in)) begin
            wb.ReadData2 = sel_data;
        end
    end
`else
    // Readers see the stored value; a write becomes visible the cycle after it lands
    always_comb begin
        wb.ReadData1 = arr_rdata1;
        wb.ReadData2 = arr_rdata2;
    end
`endif

    // Count committed writes; reset wins over a same-edge write, counter wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_cnt_q <= '0;
        end else if (commit) begin
            wb_cnt_q <= wb_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    writeback_regfile_if #(.XLEN(64)) bus ();

    writeback_regfile #(
        .XLEN  (64),
        .NREGS (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset            = 1'b1;
        bus.RegWrite_in  = 1'b0;
        bus.MemtoReg_in  = 1'b0;
        bus.rd_in        = 5'd0;
        bus.Result_in    = '0;
        bus.Read_Data_in = '0;
        bus.rs1          = 5'd0;
        bus.rs2          = 5'd0;

        // Reset for one cycle, then every register reads zero
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = 5'(i);
            bus.rs2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), bus.ReadData1, 64'd0);
            check($sformatf("reset_rd2_x%0d", 31 - i), bus.ReadData2, 64'd0);
        end
        check("reset_count", bus.wb_count, 64'd0);

        // Writeback mux selects independently of RegWrite
        bus.Result_in    = 64'h1234;
        bus.Read_Data_in = 64'hBEEF;
        bus.MemtoReg_in  = 1'b0;
        #1;
        check("mux_alu", bus.wb_data, 64'h1234);
        bus.MemtoReg_in  = 1'b1;
        #1;
        check("mux_load", bus.wb_data, 64'hBEEF);

        // ALU write to x5
        @(negedge clk);
        bus.RegWrite_in = 1'b1;
        bus.MemtoReg_in = 1'b0;
        bus.rd_in       = 5'd5;
        bus.Result_in   = 64'h1234;
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        bus.rs1         = 5'd5;
        #1;
        check("x5_after_write", bus.ReadData1, 64'h1234);
        check("count_after_x5", bus.wb_count, 64'd1);

        // Write to x0 is dropped and not counted, bypass must not leak it either
        @(negedge clk);
        bus.RegWrite_in  = 1'b1;
        bus.MemtoReg_in  = 1'b1;
        bus.rd_in        = 5'd0;
        bus.Read_Data_in = 64'hDEAD;
        bus.rs1          = 5'd0;
        #1;
        check("x0_same_cycle", bus.ReadData1, 64'd0);
        check("x0_wb_data", bus.wb_data, 64'hDEAD);
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        #1;
        check("x0_after", bus.ReadData1, 64'd0);
        check("count_after_x0", bus.wb_count, 64'd1);

        // Load path write to x6
        @(negedge clk);
        bus.RegWrite_in  = 1'b1;
        bus.MemtoReg_in  = 1'b1;
        bus.rd_in        = 5'd6;
        bus.Read_Data_in = 64'hCAFE;
        bus.Result_in    = 64'h0BAD;
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        bus.rs2         = 5'd6;
        #1;
        check("x6_load", bus.ReadData2, 64'hCAFE);
        check("count_after_x6", bus.wb_count, 64'd2);

        // Seed x7 with an old value
        @(negedge clk);
        bus.RegWrite_in = 1'b1;
        bus.MemtoReg_in = 1'b0;
        bus.rd_in       = 5'd7;
        bus.Result_in   = 64'h11;
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        #1;
        check("count_after_x7_seed", bus.wb_count, 64'd3);

        // Same-cycle read of the register being written, both ports
        @(negedge clk);
        bus.RegWrite_in = 1'b1;
        bus.MemtoReg_in = 1'b0;
        bus.rd_in       = 5'd7;
        bus.Result_in   = 64'hAA;
        bus.rs1         = 5'd7;
        bus.rs2         = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("x7_same_rd1", bus.ReadData1, 64'hAA);
        check("x7_same_rd2", bus.ReadData2, 64'hAA);
`else
        check("x7_same_rd1", bus.ReadData1, 64'h11);
        check("x7_same_rd2", bus.ReadData2, 64'h11);
`endif
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        #1;
        check("x7_next_rd1", bus.ReadData1, 64'hAA);
        check("x7_next_rd2", bus.ReadData2, 64'hAA);
        check("count_after_x7", bus.wb_count, 64'd4);

        // Disabled write leaves state alone
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        bus.rd_in       = 5'd8;
        bus.Result_in   = 64'h77;
        bus.rs1         = 5'd8;
        @(negedge clk);
        #1;
        check("x8_no_write", bus.ReadData1, 64'd0);
        check("count_no_write", bus.wb_count, 64'd4);

        // Counter wraps from all ones to zero on a committed write
        @(negedge clk);
        bus.RegWrite_in = 1'b1;
        bus.MemtoReg_in = 1'b0;
        bus.rd_in       = 5'd9;
        bus.Result_in   = 64'h99;
        bus.rs1         = 5'd9;
        force dut.wb_cnt_q = '1;
        #1;
        release dut.wb_cnt_q;
        #1;
        check("count_preload", bus.wb_count, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        bus.RegWrite_in = 1'b0;
        #1;
        check("count_wrap", bus.wb_count, 64'd0);
        check("x9_written", bus.ReadData1, 64'h99);

        // Reset beats a write on the same edge
        @(negedge clk);
        reset           = 1'b1;
        bus.RegWrite_in = 1'b1;
        bus.MemtoReg_in = 1'b0;
        bus.rd_in       = 5'd3;
        bus.Result_in   = 64'h55;
        #1;
        check("wb_data_in_reset", bus.wb_data, 64'h55);
        @(negedge clk);
        reset           = 1'b0;
        bus.RegWrite_in = 1'b0;
        bus.rs1         = 5'd3;
        bus.rs2         = 5'd5;
        #1;
        check("x3_after_reset", bus.ReadData1, 64'd0);
        check("x5_after_reset", bus.ReadData2, 64'd0);
        check("count_after_reset", bus.wb_count, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width in bits.
REQ-002 SHALL have parameter NREGS, default 32: architectural register count; the register address is 5 bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port RegWrite_in, input, 1: writeback enable from the MEM/WB register.
REQ-006 SHALL have port MemtoReg_in, input, 1: 1 selects Read_Data_in, 0 selects Result_in.
REQ-007 SHALL have port rd_in, input, 5: destination register index.
REQ-008 SHALL have port Result_in, input, XLEN: ALU result.
REQ-009 SHALL have port Read_Data_in, input, XLEN: load data.
REQ-010 SHALL have ports rs1 and rs2, input, 5 each: read addresses from the decode stage.
REQ-011 SHALL have ports ReadData1 and ReadData2, output, XLEN each: read data.
REQ-012 SHALL have port wb_data, output, XLEN: the selected writeback value, for the forwarding unit.
REQ-013 SHALL have port wb_count, output, 64: count of committed register writes.

Function
REQ-014 SHALL compute wb_data combinationally as MemtoReg_in ? Read_Data_in : Result_in, independent of RegWrite_in.
REQ-015 SHALL, on a rising clk edge with reset=0, RegWrite_in=1 and rd_in!=0, write wb_data into register[rd_in].
REQ-016 SHALL ignore every write whose rd_in is 0; x0 SHALL always read as 0.
REQ-017 SHALL drive ReadData1/ReadData2 combinationally from register[rs1]/register[rs2], with 0 returned for index 0.
REQ-018 SHALL increment wb_count by 1 on each edge where a write commits per REQ-015; wb_count SHALL wrap from 2^64-1 to 0.
REQ-019 SHALL give the same result as one write when rs1 and rs2 name the same register: both ports return the identical value.
REQ-020 SHALL make one write per edge; there are no conflicting write sources.

Reset
REQ-021 SHALL, on a rising clk edge with reset=1, clear all registers and wb_count to 0.
REQ-022 SHALL let reset take priority over a write on the same edge; that write is discarded and not counted.
REQ-023 SHALL leave wb_data combinational and unaffected by reset.

Configuration
REQ-024 SHALL provide write-to-read bypass only when macro WB_BYPASS_EN is defined: if RegWrite_in=1, rd_in!=0, reset=0 and rs1==rd_in, ReadData1 SHALL equal wb_data in the same cycle; rs2/ReadData2 behave the same way.
REQ-025 SHALL, without WB_BYPASS_EN, have read ports return the pre-edge stored value; the new value is visible from the cycle after the write.

Structure
REQ-026 SHALL take XLEN, the register address width (5) and the x0 index constant (0) from the shared package proc_pkg.
REQ-027 SHALL hold storage in one sub-module, regfile_array (NREGS x XLEN, 1 write port, 2 async read ports); the writeback mux, bypass and counter live in the top level.

Verification
REQ-028 SHALL be verified by: reset 1 cycle, then read every index -> all 0, wb_count=0.
REQ-029 SHALL be verified by: RegWrite=1, MemtoReg=0, rd=5, Result=0x1234 for 1 cycle; then rs1=5 -> ReadData1=0x1234, wb_count=1.
REQ-030 SHALL be verified by: RegWrite=1, MemtoReg=1, rd=0, Read_Data=0xDEAD -> ReadData1 for rs1=0 stays 0, wb_count unchanged.
REQ-031 SHALL be verified by: RegWrite=1, rd=7, Result=0xAA, rs1=rs2=7 in the same cycle -> with WB_BYPASS_EN both ports show 0xAA; without it, both show the old value, then 0xAA one cycle later.
REQ-032 SHALL be verified by: reset=1 and RegWrite=1, rd=3, Result=0x55 on the same edge -> register 3 reads 0, wb_count=0.
REQ-033 SHALL be verified by: forcing wb_count to 2^64-1, then one committed write -> wb_count=0.
